fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter, drives the 15-bit fetch address into the memory and captures the returned 20-bit instruction.
- Registers the instruction into the IF/ID pipeline register feeding decode.
- Handles stall, flush, branch redirect, a post-reset warm-up cycle and a halt instruction.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int PC_W    = 15;
  localparam int INSTR_W = 20;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {WARM, RUN, HALT} fetch_state_t;

  localparam instr_t NOP_INSTR    = '0;
  localparam instr_t HALT_INSTR   = 20'hFFFFF;
  localparam pc_t    RESET_VECTOR = 15'h0000;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PW = PC_W,
  parameter int IW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic          stall,
  input  logic [IW-1:0] instr,
  input  logic [PW-1:0] pc,
  output logic [IW-1:0] instr_q,
  output logic [PW-1:0] pc_q,
  output logic [PW-1:0] pc_plus1_q,
  output logic          valid_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= IW'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      instr_q    <= IW'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (!stall) begin
      instr_q    <= instr;
      pc_q       <= pc;
      pc_plus1_q <= pc + PW'(1);
      valid_q    <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, WARM/RUN/HALT control and next-PC selection,
// feeding the IF/ID register.
module fetch_stage #(
  parameter int                 PC_W         = fetch_pkg::PC_W,
  parameter int                 INSTR_W      = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter logic [INSTR_W-1:0] HALT_INSTR   = fetch_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [PC_W-1:0]    pc_target_e,
  input  logic [INSTR_W-1:0] instr_f,
  output logic [PC_W-1:0]    pc_f,
  output logic [INSTR_W-1:0] instr_d,
  output logic [PC_W-1:0]    pc_d,
  output logic [PC_W-1:0]    pc_plus1_d,
  output logic               valid_d,
  output logic               halted
);
  fetch_pkg::fetch_state_t state, state_n;
  logic [PC_W-1:0]         pc_n;
  logic                    load_d;
  logic                    halt_hit;

  // Halt only commits when nothing else is disturbing this fetch.
  assign halt_hit = (state == fetch_pkg::RUN) && (instr_f == HALT_INSTR) &&
                    !stall_f && !stall_d && !flush_d && !pc_src_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= fetch_pkg::WARM;
      pc_f  <= RESET_VECTOR;
    end else begin
      state <= state_n;
      pc_f  <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    load_d  = 1'b0;
    case (state)
      fetch_pkg::WARM: state_n = fetch_pkg::RUN;
      fetch_pkg::RUN: begin
        load_d = 1'b1;
        if (halt_hit) state_n = fetch_pkg::HALT;
      end
      fetch_pkg::HALT: begin
        // A taken branch means the halt was fetched speculatively.
        if (pc_src_e) begin
          state_n = fetch_pkg::RUN;
          load_d  = 1'b1;
        end
      end
      default: state_n = fetch_pkg::WARM;
    endcase
  end

  always_comb begin
    pc_n = pc_f;
    if (pc_src_e)
      pc_n = pc_target_e;
    else if (!stall_f && state == fetch_pkg::RUN && !halt_hit)
      pc_n = pc_f + PC_W'(1);
  end

  assign halted = (state == fetch_pkg::HALT);

  if_id_reg #(.PW(PC_W), .IW(INSTR_W)) u_if_id (
    .clk        (clk),
    .rst_n      (reset),
    .load       (load_d),
    .flush      (flush_d),
    .stall      (stall_d),
    .instr      (instr_f),
    .pc         (pc_f),
    .instr_q    (instr_d),
    .pc_q       (pc_d),
    .pc_plus1_q (pc_plus1_d),
    .valid_q    (valid_d)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [14:0] pc_target_e = '0;
  logic [19:0] instr_f;
  logic [14:0] pc_f, pc_d, pc_plus1_d;
  logic [19:0] instr_d;
  logic        valid_d, halted;

  logic        halt_en = 1'b0;
  logic [14:0] halt_addr = '0;

  always #5 clk = ~clk;

  // Memory: every word holds its own address, except an optional halt word.
  function automatic logic [19:0] mem_word(input logic [14:0] a);
    return (halt_en && a == halt_addr) ? 20'hFFFFF : {5'b0, a};
  endfunction

  assign instr_f = mem_word(pc_f);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .instr_f(instr_f), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus1_d(pc_plus1_d), .valid_d(valid_d), .halted(halted)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model
  logic [14:0] m_pc, m_pcd, m_pcp1;
  logic [19:0] m_instr;
  bit          m_valid, m_warm, m_halt;

  task automatic model_reset();
    m_pc = 15'h0; m_instr = '0; m_pcd = '0; m_pcp1 = '0;
    m_valid = 0; m_warm = 1; m_halt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_f"},       pc_f,       m_pc);
    chk({tag, ".instr_d"},    instr_d,    m_instr);
    chk({tag, ".pc_d"},       pc_d,       m_pcd);
    chk({tag, ".pc_plus1_d"}, pc_plus1_d, m_pcp1);
    chk({tag, ".valid_d"},    valid_d,    m_valid);
    chk({tag, ".halted"},     halted,     m_halt);
  endtask

  task automatic step(input string tag);
    logic [19:0] w;
    bit run, hit;
    w   = mem_word(m_pc);
    run = !m_warm && !m_halt;
    hit = run && w == 20'hFFFFF && !stall_f && !stall_d && !flush_d && !pc_src_e;
    @(posedge clk);
    #1;
    if (flush_d) begin
      m_instr = '0; m_pcd = '0; m_pcp1 = '0; m_valid = 0;
    end else if (!stall_d) begin
      if (run || (m_halt && pc_src_e)) begin
        m_instr = w; m_pcd = m_pc; m_pcp1 = 15'((m_pc + 1) % 32768); m_valid = 1;
      end else begin
        m_instr = '0; m_pcd = '0; m_pcp1 = '0; m_valid = 0;
      end
    end
    if (pc_src_e) m_pc = pc_target_e;
    else if (!stall_f && run && !hit) m_pc = 15'((m_pc + 1) % 32768);
    if (m_warm) m_warm = 0;
    else if (hit) m_halt = 1;
    else if (m_halt && pc_src_e) m_halt = 0;
    check_all(tag);
  endtask

  task automatic drive(input bit sf, input bit sd, input bit fd, input bit br, input logic [14:0] tgt);
    stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = br; pc_target_e = tgt;
  endtask

  initial begin
    model_reset();
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Warm-up bubble then sequential fetch
    step("warm");
    for (int i = 0; i < 4; i++) step("seq");

    // Hold both stages at pc_f=5
    for (int i = 0; i < 10 && m_pc != 15'd5; i++) step("to5");
    chk("at5.pc_f", pc_f, 15'd5);
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("stall");
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("resume");

    // Redirect with flush while PC stalled
    drive(1, 0, 1, 1, 15'h0100);
    step("redir");
    drive(0, 0, 0, 0, '0);
    step("redir+1");
    step("redir+2");

    // Halt at 0x0A, then redirect out to 0x20
    halt_addr = 15'h000A; halt_en = 1'b1;
    drive(0, 0, 1, 1, 15'h0008);
    step("pre_halt");
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step("halt");
    chk("halt.halted", halted, 1'b1);
    drive(0, 0, 1, 1, 15'h0020);
    step("unhalt");
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("post_halt");
    halt_en = 1'b0;

    // PC wrap
    drive(0, 0, 1, 1, 15'h7FFE);
    step("wrap_redir");
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step("wrap");

    // Asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) reset = 1'b1;
    step("rewarm");
    step("rerun");

    // Randomized traffic with a moving halt word
    halt_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit sf, sd, br, fd;
      if (i % 50 == 0) halt_addr = 15'($urandom_range(0, 40));
      sf = ($urandom_range(0, 4) == 0);
      sd = ($urandom_range(0, 9) < 7) ? sf : ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 9) == 0);
      fd = br || ($urandom_range(0, 19) == 0);
      drive(sf, sd, fd, br, 15'($urandom_range(0, 40)));
      step("rand");
    end
    drive(0, 0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
